// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction port,
// buffers {pc, instr} pairs and hands them to decode over valid/ready.
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   imem_addr       instruction address (the pc register)
//   imem_data       instruction word for imem_addr, same cycle
//   instr_out       head instruction word
//   instr_pc        head instruction byte address
//   instr_valid     head entry is valid
//   instr_ready     decode accepts head this cycle
//   redirect_valid  execute PC change (flush + reload)
//   redirect_pc     new PC, bit 0 forced to 0
//   stall           suppress fetch, FIFO may drain
//   fifo_count      number of valid entries
module instr_fetch_unit #(
    parameter logic [11:0] RESET_PC   = 12'h000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] instr_out,
    output logic [11:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [11:0] redirect_pc,
    input  logic        stall,
    output logic [2:0]  fifo_count
);

    localparam int          PW     = $clog2(FIFO_DEPTH);
    localparam logic [2:0]  DEPTH3 = 3'(FIFO_DEPTH);
    localparam logic [11:0] PC0    = RESET_PC & 12'hFFE;

    generate
        if (FIFO_DEPTH != 2 && FIFO_DEPTH != 4) begin : g_bad_depth
            $error("instr_fetch_unit: FIFO_DEPTH must be 2 or 4");
        end
    endgenerate

    logic [11:0]   pc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [2:0]    count;
    logic [11:0]   pc_q  [FIFO_DEPTH];
    logic [15:0]   ins_q [FIFO_DEPTH];

    logic pop;
    logic push;

    assign instr_valid = (count != 3'd0);
    assign pop         = instr_valid & instr_ready;
    // A full FIFO can still accept when the head leaves this cycle.
    assign push        = ~redirect_valid & ~stall &
                         ((count < DEPTH3) | pop);

    assign imem_addr  = pc;
    assign instr_out  = ins_q[head];
    assign instr_pc   = pc_q[head];
    assign fifo_count = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= PC0;
            head  <= '0;
            tail  <= '0;
            count <= 3'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_q[i]  <= 12'h000;
                ins_q[i] <= 16'h0000;
            end
        end else if (redirect_valid) begin
            // Flush wins over any pop or push this cycle.
            pc    <= redirect_pc & 12'hFFE;
            head  <= '0;
            tail  <= '0;
            count <= 3'd0;
        end else begin
            if (push) begin
                pc_q[tail]  <= pc;
                ins_q[tail] <= imem_data;
                tail        <= tail + 1'b1;
                pc          <= pc + 12'd2;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational
// instruction memory model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] instr_out;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_pc = 12'h000;
    logic        stall = 1'b0;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [11:0] a);
        case (a)
            12'h000: mem_word = 16'hF190;
            12'h320: mem_word = 16'hCEFF;
            default: mem_word = {4'h5, a};
        endcase
    endfunction

    assign imem_data = mem_word(imem_addr);

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .fifo_count     (fifo_count)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (instr_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid);
        end
        total++;
        if (fifo_count !== 3'd0) begin
            bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count);
        end
        total++;
        if (imem_addr !== 12'h000) begin
            bad++; $display("FAIL reset_addr got=%h exp=000", imem_addr);
        end
        total++;
        if ({instr_out, instr_pc} !== 28'h0) begin
            bad++;
            $display("FAIL reset_out got=%h/%h exp=0000/000",
                     instr_out, instr_pc);
        end
    endtask

    task automatic test_fetch();
        instr_ready = 1'b1;
        do_reset();
        total++;
        if (imem_addr !== 12'h000 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL fetch_c0 got=%h/%b exp=000/0",
                     imem_addr, instr_valid);
        end
        tick();
        total++;
        if (imem_addr !== 12'h002 || instr_valid !== 1'b1 ||
            instr_out !== 16'hF190 || instr_pc !== 12'h000) begin
            bad++;
            $display("FAIL fetch_c1 got=%h/%b/%h/%h exp=002/1/F190/000",
                     imem_addr, instr_valid, instr_out, instr_pc);
        end
        tick();
        total++;
        if (imem_addr !== 12'h004 || instr_pc !== 12'h002 ||
            instr_out !== 16'h5002 || fifo_count !== 3'd1) begin
            bad++;
            $display("FAIL fetch_c2 got=%h/%h/%h/%0d exp=004/002/5002/1",
                     imem_addr, instr_pc, instr_out, fifo_count);
        end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        do_reset();
        tick();
        total++;
        if (fifo_count !== 3'd1 || imem_addr !== 12'h002) begin
            bad++;
            $display("FAIL bp_c1 got=%0d/%h exp=1/002",
                     fifo_count, imem_addr);
        end
        tick(); tick(); tick();
        total++;
        if (fifo_count !== 3'd2 || imem_addr !== 12'h004) begin
            bad++;
            $display("FAIL bp_full got=%0d/%h exp=2/004",
                     fifo_count, imem_addr);
        end
        instr_ready = 1'b1;
        #1;
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 12'h000 ||
            instr_out !== 16'hF190) begin
            bad++;
            $display("FAIL bp_e0 got=%b/%h/%h exp=1/000/F190",
                     instr_valid, instr_pc, instr_out);
        end
        tick();
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 12'h002 ||
            imem_addr !== 12'h006 || fifo_count !== 3'd2) begin
            bad++;
            $display("FAIL bp_e1 got=%b/%h/%h/%0d exp=1/002/006/2",
                     instr_valid, instr_pc, imem_addr, fifo_count);
        end
        tick();
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 12'h004 ||
            instr_out !== 16'h5004) begin
            bad++;
            $display("FAIL bp_e2 got=%b/%h/%h exp=1/004/5004",
                     instr_valid, instr_pc, instr_out);
        end
    endtask

    task automatic test_redirect_full();
        instr_ready = 1'b0;
        do_reset();
        tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc = 12'h320;
        tick();
        redirect_valid = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || fifo_count !== 3'd0 ||
            imem_addr !== 12'h320) begin
            bad++;
            $display("FAIL redir_c1 got=%b/%0d/%h exp=0/0/320",
                     instr_valid, fifo_count, imem_addr);
        end
        tick();
        total++;
        if (instr_valid !== 1'b1 || instr_out !== 16'hCEFF ||
            instr_pc !== 12'h320) begin
            bad++;
            $display("FAIL redir_c2 got=%b/%h/%h exp=1/CEFF/320",
                     instr_valid, instr_out, instr_pc);
        end
    endtask

    task automatic test_wrap();
        instr_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 12'hFFF;
        tick();
        redirect_valid = 1'b0;
        total++;
        if (imem_addr !== 12'hFFE || fifo_count !== 3'd0) begin
            bad++;
            $display("FAIL wrap_c1 got=%h/%0d exp=FFE/0",
                     imem_addr, fifo_count);
        end
        tick();
        total++;
        if (imem_addr !== 12'h000 || instr_pc !== 12'hFFE ||
            instr_out !== 16'h5FFE) begin
            bad++;
            $display("FAIL wrap_c2 got=%h/%h/%h exp=000/FFE/5FFE",
                     imem_addr, instr_pc, instr_out);
        end
        instr_ready = 1'b1;
        tick();
        total++;
        if (instr_pc !== 12'h000 || instr_out !== 16'hF190 ||
            imem_addr !== 12'h002 || fifo_count !== 3'd1) begin
            bad++;
            $display("FAIL wrap_c3 got=%h/%h/%h/%0d exp=000/F190/002/1",
                     instr_pc, instr_out, imem_addr, fifo_count);
        end
    endtask

    task automatic test_stall();
        instr_ready = 1'b0;
        do_reset();
        tick(); tick();
        stall = 1'b1;
        instr_ready = 1'b1;
        tick();
        total++;
        if (fifo_count !== 3'd1 || imem_addr !== 12'h004) begin
            bad++;
            $display("FAIL stall_c1 got=%0d/%h exp=1/004",
                     fifo_count, imem_addr);
        end
        tick(); tick();
        total++;
        if (fifo_count !== 3'd0 || instr_valid !== 1'b0 ||
            imem_addr !== 12'h004) begin
            bad++;
            $display("FAIL stall_c3 got=%0d/%b/%h exp=0/0/004",
                     fifo_count, instr_valid, imem_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc = 12'h100;
        tick();
        redirect_valid = 1'b0;
        tick();
        total++;
        if (imem_addr !== 12'h100 || fifo_count !== 3'd0) begin
            bad++;
            $display("FAIL stall_redir got=%h/%0d exp=100/0",
                     imem_addr, fifo_count);
        end
        stall = 1'b0;
        tick();
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 12'h100 ||
            instr_out !== 16'h5100 || imem_addr !== 12'h102) begin
            bad++;
            $display("FAIL stall_resume got=%b/%h/%h/%h exp=1/100/5100/102",
                     instr_valid, instr_pc, instr_out, imem_addr);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (instr_valid !== 1'b0 || imem_addr !== 12'h000 ||
            fifo_count !== 3'd0) begin
            bad++;
            $display("FAIL areset got=%b/%h/%0d exp=0/000/0",
                     instr_valid, imem_addr, fifo_count);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 12'h000 ||
            instr_out !== 16'hF190 || imem_addr !== 12'h002) begin
            bad++;
            $display("FAIL areset_resume got=%b/%h/%h/%h exp=1/000/F190/002",
                     instr_valid, instr_pc, instr_out, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_backpressure();
        test_redirect_full();
        test_wrap();
        test_stall();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
